// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the 16-bit datapath.
// Ports: instruction fields, ALU zero and memory ready flow from the datapath;
// all enables, strobes, mux selects and status flow from the controller.
interface multicycle_control_if;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       halted;
  logic [1:0] fault;
  logic [3:0] state;

  // Controller side.
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, halted, fault, state
  );

  // Datapath side.
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, halted, fault, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing FSM for the 16-bit multi-cycle datapath: fetch/decode/exec/mem/wb.
// Ports: clk, rst (async, active high), bus (master modport of multicycle_control_if).
// Outputs are registered per state; only FETCH ir/pc writes and BRANCH pc_write
// are qualified combinationally by mem_ready / zero. Memory waits are guarded by a
// watchdog that halts with fault=10 after TIMEOUT unanswered cycles.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_SLTI  = 3'b110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] FAULT_FUNCT = 2'b01;
  localparam logic [1:0] FAULT_MEM   = 2'b10;

  // Last counter value before the watchdog fires: a wait seen at this count
  // would bring the counter to TIMEOUT.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  // Registered control word. The *_rdy / *_zero / *_uncond bits select how
  // the write enables are qualified at the output.
  typedef struct packed {
    logic       irw_rdy;
    logic       pcw_rdy;
    logic       pcw_zero;
    logic       pcw_uncond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t decode(input state_e s, input logic [2:0] op,
                                   input logic [3:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.irw_rdy   = 1'b1;
        c.pcw_rdy   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b10;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = fn[2:0];  // legal functs 0..4 map directly
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctrl  = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = ALU_SUB;
        c.pc_src    = 2'b01;
        c.pcw_zero  = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = 2'b10;
        c.pcw_uncond = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q;
  logic [1:0] fault_q, fault_d;
  ctrl_t      ctrl_q;
  logic       wd_expired;

  assign wd_expired = (cnt_q == WD_LAST) && !bus.mem_ready;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_HALT;
          fault_d = FAULT_MEM;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct > 4'd4) begin
              state_d = S_HALT;
              fault_d = FAULT_FUNCT;
            end else begin
              state_d = S_EXEC_R;
            end
          end
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_HALT;
        endcase
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wd_expired) begin
          state_d = S_HALT;
          fault_d = FAULT_MEM;
        end
      end
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (wd_expired) begin
          state_d = S_HALT;
          fault_d = FAULT_MEM;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Control word is decoded from the next state so it lines up with state_q.
  // Any state change clears the watchdog, which covers every entry into a
  // waiting state; staying in a waiting state without ready counts up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
      fault_q <= 2'b00;
      ctrl_q  <= decode(S_FETCH, 3'b000, 4'b0000);
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      ctrl_q  <= decode(state_d, bus.opcode, bus.funct);
      if (state_d != state_q) begin
        cnt_q <= 8'd0;
      end else if (!bus.mem_ready &&
                   (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Write enables are suppressed while rst is held so a reset landing
  // mid-instruction never commits a PC or IR load.
  assign bus.ir_write   = ctrl_q.irw_rdy & bus.mem_ready & ~rst;
  assign bus.pc_write   = ((ctrl_q.pcw_rdy & bus.mem_ready) |
                           (ctrl_q.pcw_zero & bus.zero) |
                           ctrl_q.pcw_uncond) & ~rst;
  assign bus.iord       = ctrl_q.iord;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
  assign bus.pc_src     = ctrl_q.pc_src;
  assign bus.halted     = ctrl_q.halted;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the 16-bit multi-cycle datapath. Decodes the 3-bit opcode and 4-bit funct of the latched instruction and steps an FSM through fetch, decode, execute, memory and write-back. Drives every datapath control line: PC/IR write enables, memory strobes, ALU operand selects, ALU operation, register-file write and PC source. Handles a variable-latency memory through a ready handshake with a watchdog timeout, and stops cleanly on HALT, illegal funct or memory timeout.

## Interface
- TIMEOUT, 15: maximum cycles a memory state waits for mem_ready before faulting (1..255).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  3  instruction[15:13] from IR.
- funct  in  4  instruction[3:0] from IR (R-type only).
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write  out  1  load PC.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read / mem_write  out  1 each  memory strobes, held until mem_ready.
- ir_write  out  1  load IR.
- reg_dst  out  1  write register: 0 rt (instr[9:7]), 1 rd (instr[6:4]).
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 PC, 1 regA.
- alu_src_b  out  2  00 regB, 01 constant 1, 10 sign-extended instr[6:0].
- alu_ctrl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[15:13], instr[12:0]}.
- halted  out  1  sticky: FSM in HALT.
- fault  out  2  sticky: 00 none, 01 illegal funct, 10 memory timeout.
- state  out  4  current state code (debug).

## Operation
- Opcodes: 000 R-type, 001 ADDI, 010 LW, 011 SW, 100 BEQ, 101 J, 110 SLTI, 111 HALT. Valid funct 0000-0100, mapped to alu_ctrl 000-100.
- States/codes: FETCH 0, DECODE 1, EXEC_R 2, R_WB 3, EXEC_I 4, I_WB 5, MEM_ADDR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9, BRANCH 10, JUMP 11, HALT 12.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00. ir_write and pc_write only in the cycle mem_ready=1; then -> DECODE, else stay.
- DECODE: alu_src_a=0, alu_src_b=10, ADD (branch target into ALUOut). Next: 000 -> EXEC_R (illegal funct -> HALT, fault=01); 001/110 -> EXEC_I; 010/011 -> MEM_ADDR; 100 -> BRANCH; 101 -> JUMP; 111 -> HALT.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct -> R_WB. R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD (001) or SLT (110) -> I_WB. I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, iord=1; on mem_ready -> MEM_WB. MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; on mem_ready -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write=zero -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- HALT: all enables/strobes 0, halted=1; terminal until rst.
- Unlisted outputs are 0 in each state.
- Watchdog: 8-bit counter cleared on entry to FETCH/MEM_RD/MEM_WR, increments each waiting cycle; if it reaches TIMEOUT with mem_ready=0 -> HALT, fault=10, strobes drop next cycle.

## Timing
- Reset: state=FETCH, counter=0, halted=0, fault=00; outputs are FETCH decode: mem_read=1, alu_src_b=01, all else 0 (ir_write/pc_write follow mem_ready).
- Moore outputs from state; ir_write, pc_write (FETCH) and the BRANCH pc_write are qualified combinationally by mem_ready/zero.
- Cycles with zero-wait memory: R/ADDI/SLTI 4, LW 5, SW 4, BEQ 3, J 3. Each wait cycle adds 1.
- mem_ready outside FETCH/MEM_RD/MEM_WR ignored.
- rst mid-instruction: FETCH immediately, no register or PC write in reset cycle.

## Test plan
- Reset, mem_ready=1 constantly, R ADD (opcode 000, funct 0000) -> states 0,1,2,3,0; reg_write=1, reg_dst=1 only in state 3.
- LW with mem_ready held low 3 cycles in MEM_RD -> mem_read/iord held 4 cycles, MEM_WB one cycle with mem_to_reg=1; total 8 cycles.
- BEQ with zero=1 then zero=0 -> pc_write=1, pc_src=01 in BRANCH only when zero=1.
- R-type funct 1010 -> DECODE -> HALT, fault=01, halted=1, no reg_write ever asserted.
- mem_ready never asserted in FETCH, TIMEOUT=15 -> HALT after 15 wait cycles, fault=10, mem_read=0 afterwards.
- Assert rst during MEM_WB -> state=0 asynchronously, reg_write=0, halted/fault cleared.
